// File: rtl/lcd_phy_arbiter_pkg.sv
// Shared constants and types for the LCD PHY arbiter: arbitration modes,
// RS encodings, FSM state and the owner-index width helper.
package lcd_phy_arbiter_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // A single-user arbiter still needs a 1-bit owner index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_phy_arbiter_pick.sv
// Combinational N-way picker: lowest valid index at or after the start pointer,
// wrapping modulo N; start is forced to 0 in fixed-priority mode.
module lcd_arb_pick
  import lcd_phy_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] rr_ptr,
  input  logic          mode,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0]  base;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;
  logic           hit;

  // Doubling the vector turns the wrap-around into a plain window select.
  always_comb begin
    base = (mode == 1'(ARB_RR)) ? rr_ptr : '0;
    dbl  = {valid, valid};
    rot  = dbl[base +: N];
    hit  = 1'b0;
    off  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        hit = 1'b1;
        off = IW'(k);
      end
    end
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (IW + 1)'(N)) begin
      sum = sum - (IW + 1)'(N);
    end
    idx   = sum[IW-1:0];
    grant = hit ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/lcd_phy_arbiter.sv
// Arbitrates N locked user transactions onto one registered LCD PHY beat stream.
// Latency 1 from accept to phy_*; usr_ready follows phy_ready combinationally.
module lcd_phy_arbiter
  import lcd_phy_arbiter_pkg::*;
#(
  parameter int N        = 2,
  parameter int W        = 8,
  parameter int ARB_MODE = ARB_FIXED
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [W-1:0]         phy_data,
  output logic                 phy_rs,
  output logic                 phy_last,
  output logic                 phy_valid,
  input  logic                 phy_ready,
  input  logic [W*N-1:0]       usr_data,
  input  logic [N-1:0]         usr_rs,
  input  logic [N-1:0]         usr_last,
  input  logic [N-1:0]         usr_valid,
  output logic [N-1:0]         usr_ready,
  output logic [idx_w(N)-1:0]  owner,
  output logic                 busy
);

  localparam int IW = idx_w(N);

  arb_state_t    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  pick_grant;
  logic [IW-1:0] sel;
  logic [IW-1:0] next_ptr;
  logic          can_load;
  logic          accept;
  logic          acc_last;

  lcd_arb_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .valid  (usr_valid),
    .rr_ptr (rr_ptr),
    .mode   (1'(ARB_MODE)),
    .grant  (pick_grant),
    .idx    (pick_idx)
  );

  // While locked the owner keeps the bus even with its valid low.
  always_comb begin
    can_load  = ~phy_valid | phy_ready;
    sel       = (state == ST_LOCKED) ? owner : pick_idx;
    usr_ready = '0;
    if (can_load) begin
      usr_ready = (state == ST_LOCKED) ? (N'(1) << owner) : pick_grant;
    end
    accept   = |(usr_valid & usr_ready);
    acc_last = usr_last[sel];
    next_ptr = (sel == IW'(N - 1)) ? '0 : sel + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      busy      <= 1'b0;
      phy_valid <= 1'b0;
      phy_data  <= '0;
      phy_rs    <= 1'b0;
      phy_last  <= 1'b0;
    end else begin
      if (accept) begin
        phy_valid <= 1'b1;
        phy_data  <= usr_data[W*sel +: W];
        phy_rs    <= usr_rs[sel];
        phy_last  <= acc_last;
      end else if (phy_ready) begin
        phy_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            owner <= sel;
            if (acc_last) begin
              rr_ptr <= next_ptr;
            end else begin
              state <= ST_LOCKED;
              busy  <= 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          // Next arbitration happens from IDLE, one cycle after the last beat.
          if (accept && acc_last) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_phy_arbiter.sv
// Drives a fixed-priority and a round-robin arbiter with shared stimulus and
// compares both against a transaction-level model every cycle.
module tb_lcd_phy_arbiter;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           phy_ready = 1'b0;
  logic [W*N-1:0] usr_data = '0;
  logic [N-1:0]   usr_rs = '0;
  logic [N-1:0]   usr_last = '0;
  logic [N-1:0]   usr_valid = '0;

  logic [W-1:0]  o_data  [2];
  logic          o_rs    [2];
  logic          o_last  [2];
  logic          o_valid [2];
  logic          o_busy  [2];
  logic [N-1:0]  o_ready [2];
  logic [IW-1:0] o_owner [2];

  int checks = 0;
  int errors = 0;

  // Index 0 is the fixed-priority instance, index 1 the round-robin one.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    lcd_phy_arbiter #(.N(N), .W(W), .ARB_MODE(g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .phy_data  (o_data[g]),
      .phy_rs    (o_rs[g]),
      .phy_last  (o_last[g]),
      .phy_valid (o_valid[g]),
      .phy_ready (phy_ready),
      .usr_data  (usr_data),
      .usr_rs    (usr_rs),
      .usr_last  (usr_last),
      .usr_valid (usr_valid),
      .usr_ready (o_ready[g]),
      .owner     (o_owner[g]),
      .busy      (o_busy[g])
    );
  end

  always #5 clk = ~clk;

  // Reference model: who holds the bus, where round robin starts, and the
  // single beat currently sitting in front of the PHY.
  bit         m_lock  [2];
  int         m_owner [2];
  int         m_rr    [2];
  bit         m_pv    [2];
  logic [W-1:0] m_pd  [2];
  bit         m_prs   [2];
  bit         m_plast [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_lock[m] = 0; m_owner[m] = 0; m_rr[m] = 0;
      m_pv[m] = 0; m_pd[m] = '0; m_prs[m] = 0; m_plast[m] = 0;
    end
  endtask

  function automatic int pick(input int m, input logic [N-1:0] v);
    int start;
    start = (m == 1) ? m_rr[m] : 0;
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready(input int m);
    int p;
    if (m_pv[m] && !phy_ready) return '0;
    p = m_lock[m] ? m_owner[m] : pick(m, usr_valid);
    if (p < 0) return '0;
    return N'(1) << p;
  endfunction

  task automatic model_step();
    logic [N-1:0] acc;
    int j;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_lock[m] = 0; m_owner[m] = 0; m_rr[m] = 0;
        m_pv[m] = 0; m_pd[m] = '0; m_prs[m] = 0; m_plast[m] = 0;
      end else begin
        acc = usr_valid & exp_ready(m);
        j = -1;
        for (int i = 0; i < N; i++) if (acc[i]) j = i;
        if (j >= 0) begin
          m_pv[m]    = 1;
          m_pd[m]    = usr_data[W*j +: W];
          m_prs[m]   = usr_rs[j];
          m_plast[m] = usr_last[j];
          if (!m_lock[m]) begin
            m_owner[m] = j;
            if (usr_last[j]) m_rr[m] = (j + 1) % N;
            else m_lock[m] = 1;
          end else if (usr_last[j]) begin
            m_lock[m] = 0;
            m_rr[m]   = (j + 1) % N;
          end
        end else if (phy_ready) begin
          m_pv[m] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      chk(m ? "rr usr_ready" : "fx usr_ready", 32'(o_ready[m]), 32'(exp_ready(m)));
      chk(m ? "rr phy_valid" : "fx phy_valid", 32'(o_valid[m]), 32'(m_pv[m]));
      chk(m ? "rr beat" : "fx beat", 32'({o_rs[m], o_last[m], o_data[m]}),
          32'({m_prs[m], m_plast[m], m_pd[m]}));
      chk(m ? "rr busy" : "fx busy", 32'(o_busy[m]), 32'(m_lock[m]));
      chk(m ? "rr owner" : "fx owner", 32'(o_owner[m]), 32'(m_owner[m]));
    end
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [W*N-1:0] d,
                       input logic [N-1:0] rs, input logic [N-1:0] lst,
                       input logic pr, input logic r);
    @(negedge clk);
    usr_valid = v; usr_data = d; usr_rs = rs; usr_last = lst;
    phy_ready = pr; rst = r;
    #1 compare_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  logic [7:0] t2_d [5] = '{8'h2A, 8'hA1, 8'hA2, 8'hA3, 8'hA4};

  initial begin
    model_reset();
    repeat (2) @(posedge clk);

    // Fixed priority: users 0 and 2 together, single-beat.
    drive(3'b101, {8'h33, 8'h00, 8'h11}, 3'b000, 3'b111, 1'b1, 1'b0);
    chk("t1 first grant", 32'(o_ready[0]), 32'h1);
    tick();
    drive(3'b100, {8'h33, 8'h00, 8'h11}, 3'b000, 3'b111, 1'b1, 1'b0);
    chk("t1 second grant", 32'(o_ready[0]), 32'h4);
    chk("t1 first beat", 32'(o_data[0]), 32'h11);
    tick();
    drive(3'b000, '0, 3'b000, 3'b000, 1'b1, 1'b0);
    chk("t1 second beat", 32'(o_data[0]), 32'h33);
    tick();

    // Locked command + 4 parameters from user 1 while user 0 waits.
    for (int i = 0; i < 5; i++) begin
      drive((i == 0) ? 3'b010 : 3'b011, {8'h00, t2_d[i], 8'h5A},
            {1'b0, (i != 0), 1'b0}, {1'b0, (i == 4), 1'b1}, 1'b1, 1'b0);
      chk("t2 lock ready", 32'(o_ready[0]), 32'h2);
      if (i > 0) chk("t2 contiguous beat", 32'(o_data[0]), 32'(t2_d[i-1]));
      tick();
    end
    drive(3'b001, {8'h00, 8'h00, 8'h5A}, 3'b000, 3'b001, 1'b1, 1'b0);
    chk("t2 release ready", 32'(o_ready[0]), 32'h1);
    chk("t2 last beat", 32'({o_last[0], o_data[0]}), 32'h1A4);
    tick();

    // Round robin from a clean rr_ptr.
    drive(3'b000, '0, 3'b000, 3'b000, 1'b1, 1'b1);
    tick();
    for (int k = 0; k < 6; k++) begin
      drive(3'b111, {8'h33, 8'h22, 8'h11}, 3'b111, 3'b111, 1'b1, 1'b0);
      chk("t3 rr order", 32'(o_ready[1]), 32'(3'b001 << (k % 3)));
      chk("t3 fixed order", 32'(o_ready[0]), 32'h1);
      tick();
    end

    // Backpressure holds the registered beat.
    drive(3'b001, {8'h00, 8'h00, 8'h55}, 3'b001, 3'b001, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(3'b001, {8'h00, 8'h00, 8'h66}, 3'b001, 3'b001, 1'b0, 1'b0);
      chk("t4 stall ready", 32'(o_ready[0]), 32'h0);
      chk("t4 stall beat", 32'({o_valid[0], o_rs[0], o_last[0], o_data[0]}), 32'h755);
      tick();
    end
    drive(3'b001, {8'h00, 8'h00, 8'h66}, 3'b001, 3'b001, 1'b1, 1'b0);
    chk("t4 resume ready", 32'(o_ready[0]), 32'h1);
    tick();
    drive(3'b000, '0, 3'b000, 3'b000, 1'b1, 1'b0);
    chk("t4 next beat", 32'({o_valid[0], o_data[0]}), 32'h166);
    tick();

    // Locked owner stalls with its valid low.
    drive(3'b100, {8'hC0, 8'h00, 8'h00}, 3'b100, 3'b000, 1'b1, 1'b0);
    chk("t5 start", 32'(o_ready[0]), 32'h4);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(3'b001, {8'h00, 8'h00, 8'h77}, 3'b000, 3'b001, 1'b1, 1'b0);
      chk("t5 stall lock", 32'({o_busy[0], o_owner[0], o_ready[0]}), 32'({1'b1, 2'd2, 3'b100}));
      tick();
    end
    drive(3'b101, {8'hC1, 8'h00, 8'h77}, 3'b100, 3'b101, 1'b1, 1'b0);
    chk("t5 resume", 32'(o_ready[0]), 32'h4);
    tick();
    drive(3'b001, {8'h00, 8'h00, 8'h77}, 3'b000, 3'b001, 1'b1, 1'b0);
    chk("t5 handover", 32'({o_busy[0], o_ready[0], o_data[0]}), 32'({1'b0, 3'b001, 8'hC1}));
    tick();

    // Reset while locked with a pending beat.
    drive(3'b010, {8'h00, 8'hE0, 8'h00}, 3'b000, 3'b000, 1'b1, 1'b0);
    tick();
    drive(3'b010, {8'h00, 8'hE1, 8'h00}, 3'b010, 3'b000, 1'b0, 1'b0);
    chk("t6 locked", 32'({o_busy[0], o_valid[0]}), 32'h3);
    tick();
    drive(3'b000, '0, 3'b000, 3'b000, 1'b0, 1'b1);
    tick();
    drive(3'b110, {8'hF2, 8'hF1, 8'h00}, 3'b000, 3'b110, 1'b1, 1'b0);
    chk("t6 after reset", 32'({o_valid[0], o_busy[0], o_owner[0]}), 32'h0);
    chk("t6 fresh grant", 32'(o_ready[0]), 32'h2);
    tick();
    drive(3'b000, '0, 3'b000, 3'b000, 1'b1, 1'b0);
    chk("t6 fresh beat", 32'(o_data[0]), 32'hF1);
    tick();

    // Random traffic, both modes against the model.
    for (int k = 0; k < 800; k++) begin
      drive(3'($urandom), 24'($urandom), 3'($urandom), 3'($urandom),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) == 0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
